// File: rtl/aes_mixcolumns_seq.sv
// aes_mixcolumns_seq: column-serial AES MixColumns, one column per cycle; define MIXCOL_INV_EN to add InvMixColumns.
module aes_mixcolumns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic         byp_q, byp_d;
    logic [31:0]  cur, mixed;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

`ifdef MIXCOL_INV_EN
    logic inv_q, inv_d;

    // k is one of 9/B/D/E; each set bit selects x, 2x, 4x or 8x from the xtime chain
    function automatic logic [7:0] mul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {mul(a0, 4'he) ^ mul(a1, 4'hb) ^ mul(a2, 4'hd) ^ mul(a3, 4'h9),
                mul(a0, 4'h9) ^ mul(a1, 4'he) ^ mul(a2, 4'hb) ^ mul(a3, 4'hd),
                mul(a0, 4'hd) ^ mul(a1, 4'h9) ^ mul(a2, 4'he) ^ mul(a3, 4'hb),
                mul(a0, 4'hb) ^ mul(a1, 4'hd) ^ mul(a2, 4'h9) ^ mul(a3, 4'he)};
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) inv_q <= 1'b0;
        else        inv_q <= inv_d;

    always_comb inv_d = (state_q == IDLE && in_valid) ? in_inv : inv_q;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= 128'h0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            byp_q   <= byp_d;
        end
    end

    always_comb begin
        cur = 32'h0;
        for (int c = 0; c < 4; c++)
            if (col_q == 2'(c)) cur = work_q[127-32*c -: 32];
`ifdef MIXCOL_INV_EN
        mixed = byp_q ? cur : inv_q ? inv_col(cur) : fwd_col(cur);
`else
        mixed = byp_q ? cur : fwd_col(cur);
`endif
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        byp_d   = byp_q;
        case (state_q)
            IDLE: if (in_valid) begin
                work_d  = in_state;
                byp_d   = in_bypass;
                col_d   = 2'd0;
                state_d = BUSY;
            end
            BUSY: begin
                for (int c = 0; c < 4; c++)
                    if (col_q == 2'(c)) work_d[127-32*c -: 32] = mixed;
                col_d   = col_q + 2'd1;
                state_d = (col_q == 2'd3) ? DONE : BUSY;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_state = work_q;
    end
endmodule
